coarse_seq: RTL and testbench

- Digital sequencer directly upstream of the coarse resolver summing stage in the CDU.
- Holds the 7-bit coarse angle register theta_c. This register is bits 15..9 of the CDU angle: 3 octant bits and 4 sub-octant bits.
- Decodes theta_c into the twelve active-low switch drives _DC1.._DC12.
- Samples the coarse error comparator (_TLC1H) and ambiguity detect (_ADHI) on reference-phase strobes, then steps theta_c up or down until the coarse error nulls.
- Emits one-cycle up/down pulses to the downstream angle counter.

---
 rtl/coarse_seq.sv | 186 ++++++++++++++++++
 tb/tb_coarse_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/coarse_seq.sv
// Coarse resolver sequencer: holds theta_c, drives the _DC switch bank and steps theta_c until the coarse error nulls.
// Optional 180-degree ambiguity flip is built when CDU_AMBIG_FLIP_EN is defined.
module coarse_seq #(
    parameter int unsigned SETTLE_CYC  = 16,
    parameter int unsigned LOCK_CNT    = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coarse_en,
    input  logic       ref_pos,
    input  logic       ref_neg,
    input  logic       _TLC1H,
    input  logic       _ADHI,
    input  logic       load,
    input  logic [6:0] load_val,
    output logic       _DC1,
    output logic       _DC2,
    output logic       _DC3,
    output logic       _DC4,
    output logic       _DC5,
    output logic       _DC6,
    output logic       _DC7,
    output logic       _DC8,
    output logic       _DC9,
    output logic       _DC10,
    output logic       _DC11,
    output logic       _DC12,
    output logic [6:0] theta_c,
    output logic       cnt_up,
    output logic       cnt_dn,
    output logic       coarse_ok,
    output logic       amb_flip
);

    localparam int unsigned SETTLE_W = 8;
    localparam int unsigned LOCK_W   = 4;
    localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE_CYC);
    localparam logic [LOCK_W-1:0]   LOCK_MAX  = LOCK_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t                 state;
    logic [SETTLE_W-1:0]    settle_cnt;
    logic [LOCK_W-1:0]      lock_cnt;
    logic [SYNC_STAGES-1:0] tlc_sync;
    logic [11:0]            dc_n;
    logic                   amb_q;

    logic tlc;
    logic strobe_one;
    logic step_dn;
    logic step_up;
    logic flip_hit;

    // Asserted-high switch map: bits 0..7 = DC1..DC8 (octant pair), bits 8..11 = DC9..DC12 (sub-octant).
    function automatic logic [11:0] dc_decode(input logic [6:0] th);
        logic [7:0] oct;
        case (th[6:4])
            3'd0:    oct = 8'h14;
            3'd1:    oct = 8'h28;
            3'd2:    oct = 8'h22;
            3'd3:    oct = 8'h11;
            3'd4:    oct = 8'h41;
            3'd5:    oct = 8'h82;
            3'd6:    oct = 8'h88;
            default: oct = 8'h44;
        endcase
        return {th[0], th[1], th[2], th[3], oct};
    endfunction

    assign tlc        = tlc_sync[SYNC_STAGES-1];
    assign strobe_one = ref_pos ^ ref_neg;
    assign step_dn    = strobe_one & ref_pos & tlc;
    assign step_up    = strobe_one & ref_neg & tlc;

`ifdef CDU_AMBIG_FLIP_EN
    logic [SYNC_STAGES-1:0] adi_sync;
    logic                   adi;

    assign adi      = adi_sync[SYNC_STAGES-1];
    assign flip_hit = strobe_one & ref_pos & adi & (theta_c[6:4] >= 3'd2) & (theta_c[6:4] <= 3'd5);

    always_ff @(posedge clk) begin
        if (rst) adi_sync <= '0;
        else     adi_sync <= {adi_sync[SYNC_STAGES-2:0], _ADHI};
    end
`else
    logic unused_adhi;

    assign unused_adhi = _ADHI;
    assign flip_hit    = 1'b0;
`endif

    // Sequencer: load pre-empts everything, disable forces IDLE, otherwise settle/wait stepping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            lock_cnt   <= '0;
            tlc_sync   <= '0;
            theta_c    <= 7'd0;
            dc_n       <= ~dc_decode(7'd0);
            cnt_up     <= 1'b0;
            cnt_dn     <= 1'b0;
            amb_q      <= 1'b0;
            coarse_ok  <= 1'b0;
        end else begin
            tlc_sync <= {tlc_sync[SYNC_STAGES-2:0], _TLC1H};
            dc_n     <= ~dc_decode(theta_c);
            cnt_up   <= 1'b0;
            cnt_dn   <= 1'b0;
            amb_q    <= 1'b0;

            if (load) begin
                theta_c   <= load_val;
                lock_cnt  <= '0;
                coarse_ok <= 1'b0;
                if (coarse_en) begin
                    state      <= S_SETTLE;
                    settle_cnt <= SETTLE_LD;
                end else begin
                    state <= S_IDLE;
                end
            end else if (!coarse_en) begin
                state     <= S_IDLE;
                lock_cnt  <= '0;
                coarse_ok <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state      <= S_SETTLE;
                        settle_cnt <= SETTLE_LD;
                        coarse_ok  <= 1'b0;
                    end
                    S_SETTLE: begin
                        settle_cnt <= settle_cnt - SETTLE_W'(1);
                        if (settle_cnt <= SETTLE_W'(1)) state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (flip_hit) begin
                            theta_c    <= theta_c ^ 7'h40;
                            amb_q      <= 1'b1;
                            lock_cnt   <= '0;
                            coarse_ok  <= 1'b0;
                            state      <= S_SETTLE;
                            settle_cnt <= SETTLE_LD;
                        end else if (step_dn || step_up) begin
                            theta_c    <= step_up ? theta_c + 7'd1 : theta_c - 7'd1;
                            cnt_up     <= step_up;
                            cnt_dn     <= step_dn;
                            lock_cnt   <= '0;
                            coarse_ok  <= 1'b0;
                            state      <= S_SETTLE;
                            settle_cnt <= SETTLE_LD;
                        end else if (strobe_one) begin
                            if (lock_cnt != LOCK_MAX) lock_cnt <= lock_cnt + LOCK_W'(1);
                            coarse_ok <= (lock_cnt >= LOCK_MAX - LOCK_W'(1));
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign amb_flip = amb_q;

    assign _DC1  = dc_n[0];
    assign _DC2  = dc_n[1];
    assign _DC3  = dc_n[2];
    assign _DC4  = dc_n[3];
    assign _DC5  = dc_n[4];
    assign _DC6  = dc_n[5];
    assign _DC7  = dc_n[6];
    assign _DC8  = dc_n[7];
    assign _DC9  = dc_n[8];
    assign _DC10 = dc_n[9];
    assign _DC11 = dc_n[10];
    assign _DC12 = dc_n[11];

endmodule

// File: tb/tb_coarse_seq.sv
// Directed bench for coarse_seq: pulse scoreboard plus direct state checks.
module tb_coarse_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       coarse_en;
    logic       ref_pos;
    logic       ref_neg;
    logic       tlc_in;
    logic       adi_in;
    logic       load;
    logic [6:0] load_val;
    logic       _DC1, _DC2, _DC3, _DC4, _DC5, _DC6, _DC7, _DC8, _DC9, _DC10, _DC11, _DC12;
    logic [6:0] theta_c;
    logic       cnt_up, cnt_dn, coarse_ok, amb_flip;
    logic [11:0] dc_vec;

    typedef struct packed {
        logic       up;
        logic       dn;
        logic       flip;
        logic [6:0] th;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    always #5 clk = ~clk;

    coarse_seq #(.SETTLE_CYC(16), .LOCK_CNT(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .coarse_en(coarse_en),
        .ref_pos(ref_pos), .ref_neg(ref_neg),
        ._TLC1H(tlc_in), ._ADHI(adi_in),
        .load(load), .load_val(load_val),
        ._DC1(_DC1), ._DC2(_DC2), ._DC3(_DC3), ._DC4(_DC4), ._DC5(_DC5), ._DC6(_DC6),
        ._DC7(_DC7), ._DC8(_DC8), ._DC9(_DC9), ._DC10(_DC10), ._DC11(_DC11), ._DC12(_DC12),
        .theta_c(theta_c), .cnt_up(cnt_up), .cnt_dn(cnt_dn),
        .coarse_ok(coarse_ok), .amb_flip(amb_flip)
    );

    assign dc_vec = {_DC12, _DC11, _DC10, _DC9, _DC8, _DC7, _DC6, _DC5, _DC4, _DC3, _DC2, _DC1};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected active-low switch vector from the octant/sub-octant table (bit i = DC(i+1)).
    function automatic logic [11:0] exp_dc(input logic [6:0] th);
        int         pa[8] = '{3, 4, 2, 1, 1, 2, 4, 3};
        int         pb[8] = '{5, 6, 6, 5, 7, 8, 8, 7};
        logic [11:0] v;
        int         k;
        v = '1;
        k = int'(th[6:4]);
        v[pa[k]-1] = 1'b0;
        v[pb[k]-1] = 1'b0;
        if (th[3]) v[8]  = 1'b0;
        if (th[2]) v[9]  = 1'b0;
        if (th[1]) v[10] = 1'b0;
        if (th[0]) v[11] = 1'b0;
        return v;
    endfunction

    task automatic push_ev(input logic up, input logic dn, input logic flip, input logic [6:0] th);
        ev_t e;
        e.up = up; e.dn = dn; e.flip = flip; e.th = th;
        exp_q.push_back(e);
    endtask

    // Monitor: every pulse the DUT emits must match the oldest expected event.
    always @(negedge clk) begin
        ev_t e;
        if (rst === 1'b0 && (cnt_up || cnt_dn || amb_flip)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got up=%b dn=%b flip=%b theta=%h, no pulse expected",
                         cnt_up, cnt_dn, amb_flip, theta_c);
            end else begin
                e = exp_q.pop_front();
                chk("pulse", 32'({cnt_up, cnt_dn, amb_flip, theta_c}), 32'({e.up, e.dn, e.flip, e.th}));
            end
        end
    end

    initial begin
        rst = 1'b1; coarse_en = 1'b0; ref_pos = 1'b0; ref_neg = 1'b0;
        tlc_in = 1'b0; adi_in = 1'b0; load = 1'b0; load_val = 7'd0;

        tick(2);
        chk("reset_theta", 32'(theta_c), 32'h00);
        chk("reset_dc", 32'(dc_vec), 32'hFEB);
        chk("reset_flags", 32'({cnt_up, cnt_dn, amb_flip, coarse_ok}), 32'h0);

        // Step down from 0x10 with tlc held high.
        rst = 1'b0; coarse_en = 1'b1; tlc_in = 1'b1; load_val = 7'h10; load = 1'b1;
        tick(1);
        load = 1'b0;
        chk("load_theta", 32'(theta_c), 32'h10);
        tick(19);
        ref_pos = 1'b1; push_ev(1'b0, 1'b1, 1'b0, 7'h0F);
        tick(1);
        ref_pos = 1'b0;
        chk("step1_theta", 32'(theta_c), 32'h0F);
        tick(1);
        chk("step1_dc", 32'(dc_vec), 32'h0EB);
        tick(3);
        ref_pos = 1'b1;
        tick(1);
        ref_pos = 1'b0;
        chk("settle_ignore", 32'(theta_c), 32'h0F);
        tick(14);
        ref_pos = 1'b1; push_ev(1'b0, 1'b1, 1'b0, 7'h0E);
        tick(1);
        ref_pos = 1'b0;
        chk("step2_theta", 32'(theta_c), 32'h0E);

        // Wrap 0x7F -> 0x00 on ref_neg.
        load_val = 7'h7F; load = 1'b1;
        tick(1);
        load = 1'b0;
        tick(19);
        ref_neg = 1'b1; push_ev(1'b1, 1'b0, 1'b0, 7'h00);
        tick(1);
        ref_neg = 1'b0;
        chk("wrap_theta", 32'(theta_c), 32'h00);
        chk("wrap_up_hi", 32'(cnt_up), 32'h1);
        chk("wrap_dc_old", 32'(dc_vec), 32'h0BB);
        tick(1);
        chk("wrap_up_lo", 32'(cnt_up), 32'h0);
        chk("wrap_dc_new", 32'(dc_vec), 32'hFEB);

        // Lock: four no-step strobes, then a step drops coarse_ok.
        tlc_in = 1'b0;
        tick(20);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) ref_pos = 1'b1;
            else            ref_neg = 1'b1;
            tick(1);
            ref_pos = 1'b0; ref_neg = 1'b0;
            if (i == 2) chk("lock_early", 32'(coarse_ok), 32'h0);
            if (i == 3) chk("lock_set", 32'(coarse_ok), 32'h1);
            tick(2);
        end
        chk("lock_hold", 32'(coarse_ok), 32'h1);
        tlc_in = 1'b1;
        tick(4);
        ref_pos = 1'b1; push_ev(1'b0, 1'b1, 1'b0, 7'h7F);
        tick(1);
        ref_pos = 1'b0;
        chk("unlock_ok", 32'(coarse_ok), 32'h0);
        chk("unlock_theta", 32'(theta_c), 32'h7F);

        // Simultaneous strobes are ignored; load pre-empts a strobe.
        tick(20);
        ref_pos = 1'b1; ref_neg = 1'b1;
        tick(1);
        ref_pos = 1'b0; ref_neg = 1'b0;
        chk("both_strobes", 32'(theta_c), 32'h7F);
        tick(1);
        load_val = 7'h25; load = 1'b1; ref_neg = 1'b1;
        tick(1);
        load = 1'b0; ref_neg = 1'b0;
        chk("load_vs_strobe", 32'(theta_c), 32'h25);
        chk("load_no_up", 32'(cnt_up), 32'h0);
        tick(1);
        chk("load_dc", 32'(dc_vec), 32'(exp_dc(7'h25)));

        // Ambiguity detect at octant 3.
        load_val = 7'h30; adi_in = 1'b1; load = 1'b1;
        tick(1);
        load = 1'b0;
        tick(19);
        ref_pos = 1'b1;
`ifdef CDU_AMBIG_FLIP_EN
        push_ev(1'b0, 1'b0, 1'b1, 7'h70);
`else
        push_ev(1'b0, 1'b1, 1'b0, 7'h2F);
`endif
        tick(1);
        ref_pos = 1'b0; adi_in = 1'b0;
`ifdef CDU_AMBIG_FLIP_EN
        chk("amb_theta", 32'(theta_c), 32'h70);
        tick(1);
        chk("amb_dc", 32'(dc_vec), 32'hFBB);
`else
        chk("amb_theta", 32'(theta_c), 32'h2F);
        tick(1);
        chk("amb_dc", 32'(dc_vec), 32'h0DD);
`endif

        // Reset in the middle of SETTLE.
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midrst_theta", 32'(theta_c), 32'h00);
        chk("midrst_flags", 32'({cnt_up, cnt_dn, amb_flip, coarse_ok}), 32'h0);
        tick(1);
        chk("midrst_dc", 32'(dc_vec), 32'(exp_dc(7'h00)));

        tick(5);
        chk("queue_drain", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
